gshare_predictor: RTL and testbench
===================================

# gshare_predictor

Parametrised direction predictor for the fetch stage. It replaces the per-PC 2-bit counter table with a table of saturating counters indexed by the PC XOR a global history register (GHR). The GHR is updated speculatively at prediction time and repaired on a mispredict. Prediction is combinational in IF, counter training happens in ID, and a reset-driven sweep FSM initialises the table so that no simulation-only initial block is needed.

## Interface
- INDEX_WIDTH, 6: table index bits; TABLE_ENTRIES = 2**INDEX_WIDTH.
- GHR_WIDTH, 6: global history bits; legal range 1..INDEX_WIDTH.
- CTR_WIDTH, 2: saturating counter width; legal range 1..4.
- HASH_EN, 1: 1 selects gshare (PC XOR GHR); 0 selects bimodal (PC only, GHR still maintained).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- init_done  out  1  table sweep complete; 0 during reset and INIT.
- pc_f  in  32  IF-stage PC.
- predict_fire  in  1  IF advances a control-flow instruction this cycle.
- bht_taken  out  1  predicted direction for pc_f.
- pred_ghr  out  GHR_WIDTH  GHR value used for this prediction; piped to ID with the instruction.
- pc_d  in  32  ID-stage PC of the resolving instruction.
- cflow_valid  in  1  train the counter for pc_d this cycle.
- cflow_taken  in  1  resolved direction.
- cflow_ghr  in  GHR_WIDTH  pred_ghr that was captured when pc_d was predicted.
- mispredict  in  1  the resolved direction differs from the prediction; qualified by cflow_valid.

## Operation
- Counter encoding: unsigned CTR_WIDTH bits. Init value is WNT = 2**(CTR_WIDTH-1)-1 (CTR_WIDTH=1 gives 0). Predict taken = counter MSB.
- Predict index: pc_f[2 +: INDEX_WIDTH] ^ ({zero-extended ghr} if HASH_EN, else 0).
- Update index: pc_d[2 +: INDEX_WIDTH] ^ ({zero-extended cflow_ghr} if HASH_EN, else 0).
- Training (RUN state, cflow_valid=1) is a read-modify-write in one cycle:
  - Taken: counter+1, saturating at 2**CTR_WIDTH-1.
  - Not taken: counter-1, saturating at 0.
- GHR update priority, per cycle:
  1. cflow_valid & mispredict: ghr <= {cflow_ghr[GHR_WIDTH-2:0], cflow_taken}, which repairs history. When GHR_WIDTH=1, ghr <= cflow_taken.
  2. Else predict_fire: ghr <= {ghr[GHR_WIDTH-2:0], bht_taken}, a speculative shift.
  3. Else hold.
- pred_ghr = current ghr (the pre-shift value).
- FSM states:
  - INIT: write WNT to entry init_idx each cycle, then init_idx++. After the write to TABLE_ENTRIES-1, go to RUN.
  - RUN: normal operation; remain there until rst.
- During INIT:
  - bht_taken=0 and pred_ghr=0.
  - ghr is held at 0.
  - cflow_valid, mispredict and predict_fire are ignored.
- Reset (asynchronous assert, any time, including mid-sweep or mid-training):
  - state=INIT, init_idx=0, ghr=0, init_done=0.
  - The sweep restarts from entry 0.
  - Table contents are don't-care until rewritten.

## Timing
- Reset values: init_done=0, bht_taken=0, pred_ghr=0.
- The sweep starts on the first rising edge after rst deasserts. init_done rises after exactly TABLE_ENTRIES edges (64 by default).
- bht_taken and pred_ghr are combinational from pc_f, ghr and table state, with no added latency. The table uses asynchronous-read distributed RAM.
- Training write lands on the clock edge. A predict that reads the same index in the same cycle sees the old value; the new value is visible the next cycle.
- GHR repair takes effect the cycle after mispredict. A predict_fire in the same cycle is discarded, because the IF instruction is being flushed.
- predict_fire with no update shifts the GHR; the prediction in the next cycle uses the shifted GHR.
- Back-to-back training of the same index on consecutive cycles accumulates correctly (each cycle reads the previous write).

## Test plan
- Reset/init: pulse rst mid-sweep at cycle 20 → init_done=0, then init_done=1 exactly 64 cycles after deassert; every index predicts 0 (WNT=1).
- Saturation (HASH_EN=0): train pc_d=0x40 taken ×4 → counter steps 1→2→3→3 and bht_taken=1 from the 1st update; then not-taken ×4 → 3→2→1→0→0, with bht_taken=0 after the 2nd.
- Speculative GHR: 3 predict_fire at pc_f whose counters predict 1,0,1 → pred_ghr sequence 0b000000, 0b000001, 0b000010, final ghr=0b000101.
- Repair priority: ghr=0b101101 with cflow_valid=mispredict=1, cflow_ghr=0b000011, cflow_taken=0, and predict_fire=1 in the same cycle → ghr=0b000110 next cycle.
- gshare aliasing: pc_f=0x0 with ghr=0b000001 reads the same entry as pc_f=0x4 with ghr=0 → training one flips the prediction of the other.
- Same-cycle read/write: train the index that pc_f reads from counter=1, taken → bht_taken=0 in that cycle and 1 in the next.

Source files
------------

// File: rtl/gshare_predictor.sv
// gshare_predictor: fetch-stage direction predictor.
// A table of saturating counters is indexed by PC XOR global history
// (or by PC alone when HASH_EN=0). Prediction is combinational, training is
// a single-cycle read-modify-write, and the GHR is shifted speculatively at
// prediction time and repaired from the ID-stage snapshot on a mispredict.
// After reset a sweep FSM writes the weakly-not-taken value into every entry,
// so the table needs no reset network and no initial block.
//
// Legal parameter ranges: 1 <= GHR_WIDTH <= INDEX_WIDTH, 1 <= CTR_WIDTH <= 4,
// INDEX_WIDTH <= 29 so that the index field fits inside a 32-bit PC.

module gshare_predictor #(
  parameter int INDEX_WIDTH = 6,
  parameter int GHR_WIDTH   = 6,
  parameter int CTR_WIDTH   = 2,
  parameter bit HASH_EN     = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 init_done,
  // IF-stage prediction interface
  input  logic [31:0]          pc_f,
  input  logic                 predict_fire,
  output logic                 bht_taken,
  output logic [GHR_WIDTH-1:0] pred_ghr,
  // ID-stage resolution interface
  input  logic [31:0]          pc_d,
  input  logic                 cflow_valid,
  input  logic                 cflow_taken,
  input  logic [GHR_WIDTH-1:0] cflow_ghr,
  input  logic                 mispredict
);

  localparam int TABLE_ENTRIES = 2 ** INDEX_WIDTH;

  // Weakly-not-taken: one below the taken threshold (0 for 1-bit counters).
  localparam logic [CTR_WIDTH-1:0] CTR_WNT  = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);
  localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;
  localparam logic [CTR_WIDTH-1:0] CTR_MIN  = '0;
  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = '1;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [INDEX_WIDTH-1:0] init_idx;
  logic [INDEX_WIDTH-1:0] init_idx_next;
  logic [GHR_WIDTH-1:0]   ghr;
  logic [GHR_WIDTH-1:0]   ghr_next;

  // Counter storage: asynchronous read, single synchronous write port.
  logic [CTR_WIDTH-1:0]   ctr_table [TABLE_ENTRIES];

  logic                   running;
  logic [INDEX_WIDTH-1:0] pred_hash;
  logic [INDEX_WIDTH-1:0] pred_idx;
  logic [CTR_WIDTH-1:0]   pred_ctr;
  logic [INDEX_WIDTH-1:0] upd_hash;
  logic [INDEX_WIDTH-1:0] upd_idx;
  logic [CTR_WIDTH-1:0]   upd_ctr;
  logic [CTR_WIDTH-1:0]   trained_ctr;

  logic                   train_en;
  logic                   repair_en;
  logic                   shift_en;
  logic [GHR_WIDTH:0]     repair_cat;
  logic [GHR_WIDTH:0]     spec_cat;

  logic                   tbl_we;
  logic [INDEX_WIDTH-1:0] tbl_waddr;
  logic [CTR_WIDTH-1:0]   tbl_wdata;

  assign running   = (state == ST_RUN);
  assign init_done = running;

  // History only perturbs the index in gshare mode; it is still tracked in
  // bimodal mode so pred_ghr stays meaningful to the pipeline.
  assign pred_hash = HASH_EN ? INDEX_WIDTH'(ghr)       : '0;
  assign upd_hash  = HASH_EN ? INDEX_WIDTH'(cflow_ghr) : '0;
  assign pred_idx  = pc_f[2 +: INDEX_WIDTH] ^ pred_hash;
  assign upd_idx   = pc_d[2 +: INDEX_WIDTH] ^ upd_hash;

  assign pred_ctr  = ctr_table[pred_idx];
  assign upd_ctr   = ctr_table[upd_idx];

  // Outputs are forced quiet until the sweep has filled the table.
  assign bht_taken = running & pred_ctr[CTR_WIDTH-1];
  assign pred_ghr  = running ? ghr : '0;

  // Qualify all pipeline requests with RUN so the sweep cannot be disturbed.
  assign train_en  = running & cflow_valid;
  assign repair_en = train_en & mispredict;
  assign shift_en  = running & predict_fire & ~repair_en;

  // Shift-in concatenations; the dropped MSB also makes GHR_WIDTH=1 work.
  assign repair_cat = {cflow_ghr, cflow_taken};
  assign spec_cat   = {ghr, bht_taken};

  // Saturating increment/decrement of the counter being resolved.
  always_comb begin
    trained_ctr = upd_ctr;
    if (cflow_taken) begin
      if (upd_ctr != CTR_MAX) trained_ctr = upd_ctr + CTR_WIDTH'(1);
    end else begin
      if (upd_ctr != CTR_MIN) trained_ctr = upd_ctr - CTR_WIDTH'(1);
    end
  end

  // Single write port shared by the init sweep and ID-stage training.
  always_comb begin
    tbl_we    = 1'b0;
    tbl_waddr = '0;
    tbl_wdata = '0;
    if (state == ST_INIT) begin
      tbl_we    = 1'b1;
      tbl_waddr = init_idx;
      tbl_wdata = CTR_WNT;
    end else if (train_en) begin
      tbl_we    = 1'b1;
      tbl_waddr = upd_idx;
      tbl_wdata = trained_ctr;
    end
  end

  // Table write; contents are not reset, the sweep rewrites them instead.
  always_ff @(posedge clk) begin
    if (tbl_we) ctr_table[tbl_waddr] <= tbl_wdata;
  end

  // Sweep sequencing: walk every index once, then stay in RUN.
  always_comb begin
    state_next    = state;
    init_idx_next = init_idx;
    case (state)
      ST_INIT: begin
        init_idx_next = init_idx + INDEX_WIDTH'(1);
        if (init_idx == LAST_IDX) state_next = ST_RUN;
      end
      ST_RUN: begin
        state_next = ST_RUN;
      end
      default: begin
        state_next    = ST_INIT;
        init_idx_next = '0;
      end
    endcase
  end

  // History next value: repair beats the speculative shift, which is flushed.
  always_comb begin
    ghr_next = ghr;
    if (repair_en) begin
      ghr_next = repair_cat[GHR_WIDTH-1:0];
    end else if (shift_en) begin
      ghr_next = spec_cat[GHR_WIDTH-1:0];
    end
  end

  // Control state with asynchronous reset back to the start of the sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_INIT;
      init_idx <= '0;
      ghr      <= '0;
    end else begin
      state    <= state_next;
      init_idx <= init_idx_next;
      ghr      <= ghr_next;
    end
  end

  // PC bits outside the index field and the shifted-out history bits.
  logic unused_bits;
  assign unused_bits = ^{pc_f[31:2+INDEX_WIDTH], pc_f[1:0],
                         pc_d[31:2+INDEX_WIDTH], pc_d[1:0],
                         repair_cat[GHR_WIDTH], spec_cat[GHR_WIDTH]};

endmodule

// File: tb/tb_gshare_predictor.sv
// tb_gshare_predictor: directed test of gshare_predictor.
// Two instances share all inputs: one in gshare mode, one in bimodal mode.
// Expected values are hand-computed from the counter/GHR rules.

module tb_gshare_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] pc_f;
  logic        predict_fire;
  logic [31:0] pc_d;
  logic        cflow_valid;
  logic        cflow_taken;
  logic [5:0]  cflow_ghr;
  logic        mispredict;

  logic        init_done_g;
  logic        bht_taken_g;
  logic [5:0]  pred_ghr_g;
  logic        init_done_b;
  logic        bht_taken_b;
  logic [5:0]  pred_ghr_b;

  int checks   = 0;
  int failures = 0;

  gshare_predictor #(
    .INDEX_WIDTH(6), .GHR_WIDTH(6), .CTR_WIDTH(2), .HASH_EN(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .init_done(init_done_g),
    .pc_f(pc_f), .predict_fire(predict_fire),
    .bht_taken(bht_taken_g), .pred_ghr(pred_ghr_g),
    .pc_d(pc_d), .cflow_valid(cflow_valid), .cflow_taken(cflow_taken),
    .cflow_ghr(cflow_ghr), .mispredict(mispredict)
  );

  gshare_predictor #(
    .INDEX_WIDTH(6), .GHR_WIDTH(6), .CTR_WIDTH(2), .HASH_EN(1'b0)
  ) dut_bi (
    .clk(clk), .rst(rst), .init_done(init_done_b),
    .pc_f(pc_f), .predict_fire(predict_fire),
    .bht_taken(bht_taken_b), .pred_ghr(pred_ghr_b),
    .pc_d(pc_d), .cflow_valid(cflow_valid), .cflow_taken(cflow_taken),
    .cflow_ghr(cflow_ghr), .mispredict(mispredict)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value with its expectation and tally the result.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drive every DUT input at once, then let combinational outputs settle.
  task automatic applyStimulus(input logic [31:0] pcf, input logic pf,
                               input logic [31:0] pcd, input logic cv,
                               input logic ct, input logic [5:0] cg,
                               input logic mp);
    pc_f         = pcf;
    predict_fire = pf;
    pc_d         = pcd;
    cflow_valid  = cv;
    cflow_taken  = ct;
    cflow_ghr    = cg;
    mispredict   = mp;
    #1;
  endtask

  // Advance one clock and sample just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Idle apart from the IF-stage PC.
  task automatic idleAt(input logic [31:0] pcf);
    applyStimulus(pcf, 1'b0, 32'h0, 1'b0, 1'b0, 6'h0, 1'b0);
  endtask

  localparam logic [3:0] SAT_TAKEN_EXP = 4'b1111;
  localparam logic [3:0] SAT_NT_EXP    = 4'b0001;

  initial begin
    logic [3:0] exp_vec;
    rst = 1'b1;
    idleAt(32'h0);

    // Reset values.
    step();
    step();
    checkOutput("reset_init_done", {31'b0, init_done_g}, 32'd0);
    checkOutput("reset_bht", {31'b0, bht_taken_g}, 32'd0);
    checkOutput("reset_pred_ghr", {26'b0, pred_ghr_g}, 32'd0);

    // Start a sweep, then interrupt it after 20 edges.
    @(negedge clk);
    rst = 1'b0;
    repeat (20) step();
    checkOutput("mid_sweep_init_done", {31'b0, init_done_g}, 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("mid_sweep_reset_init_done", {31'b0, init_done_g}, 32'd0);
    step();
    @(negedge clk);
    rst = 1'b0;

    // Garbage requests during the sweep must be ignored.
    applyStimulus(32'h0, 1'b1, 32'h0, 1'b1, 1'b1, 6'h3f, 1'b1);
    repeat (63) step();
    checkOutput("sweep_63_init_done", {31'b0, init_done_g}, 32'd0);
    checkOutput("sweep_63_pred_ghr", {26'b0, pred_ghr_g}, 32'd0);
    step();
    checkOutput("sweep_64_init_done", {31'b0, init_done_g}, 32'd1);
    checkOutput("sweep_64_init_done_bi", {31'b0, init_done_b}, 32'd1);
    idleAt(32'h0);
    checkOutput("post_init_ghr", {26'b0, pred_ghr_g}, 32'd0);

    // Every entry starts weakly-not-taken.
    for (int i = 0; i < 64; i++) begin
      idleAt(32'(i) << 2);
      checkOutput($sformatf("init_wnt_g_%0d", i), {31'b0, bht_taken_g}, 32'd0);
      checkOutput($sformatf("init_wnt_b_%0d", i), {31'b0, bht_taken_b}, 32'd0);
    end

    // Saturation at index 16: taken x4, not-taken x4, then taken x2.
    applyStimulus(32'h40, 1'b0, 32'h40, 1'b1, 1'b1, 6'h0, 1'b0);
    exp_vec = SAT_TAKEN_EXP;
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput($sformatf("sat_taken_b_%0d", i), {31'b0, bht_taken_b}, {31'b0, exp_vec[i]});
      checkOutput($sformatf("sat_taken_g_%0d", i), {31'b0, bht_taken_g}, {31'b0, exp_vec[i]});
    end
    applyStimulus(32'h40, 1'b0, 32'h40, 1'b1, 1'b0, 6'h0, 1'b0);
    exp_vec = SAT_NT_EXP;
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput($sformatf("sat_nt_b_%0d", i), {31'b0, bht_taken_b}, {31'b0, exp_vec[i]});
    end
    applyStimulus(32'h40, 1'b0, 32'h40, 1'b1, 1'b1, 6'h0, 1'b0);
    step();
    checkOutput("sat_floor_up1", {31'b0, bht_taken_b}, 32'd0);
    step();
    checkOutput("sat_floor_up2", {31'b0, bht_taken_b}, 32'd1);
    idleAt(32'h40);

    // Speculative history: predictions 1,0,1 in gshare; 1,0,0 in bimodal.
    applyStimulus(32'h40, 1'b1, 32'h0, 1'b0, 1'b0, 6'h0, 1'b0);
    checkOutput("spec0_ghr", {26'b0, pred_ghr_g}, 32'd0);
    checkOutput("spec0_bht", {31'b0, bht_taken_g}, 32'd1);
    checkOutput("spec0_bht_bi", {31'b0, bht_taken_b}, 32'd1);
    step();
    applyStimulus(32'h80, 1'b1, 32'h0, 1'b0, 1'b0, 6'h0, 1'b0);
    checkOutput("spec1_ghr", {26'b0, pred_ghr_g}, 32'd1);
    checkOutput("spec1_bht", {31'b0, bht_taken_g}, 32'd0);
    checkOutput("spec1_ghr_bi", {26'b0, pred_ghr_b}, 32'd1);
    step();
    applyStimulus(32'h48, 1'b1, 32'h0, 1'b0, 1'b0, 6'h0, 1'b0);
    checkOutput("spec2_ghr", {26'b0, pred_ghr_g}, 32'd2);
    checkOutput("spec2_bht", {31'b0, bht_taken_g}, 32'd1);
    checkOutput("spec2_bht_bi", {31'b0, bht_taken_b}, 32'd0);
    step();
    idleAt(32'h48);
    checkOutput("spec_final_ghr", {26'b0, pred_ghr_g}, 32'h05);
    checkOutput("spec_final_ghr_bi", {26'b0, pred_ghr_b}, 32'h04);

    // Load ghr=0b101101 through a repair, then repair with a competing fire.
    applyStimulus(32'h48, 1'b0, 32'h0, 1'b1, 1'b1, 6'b010110, 1'b1);
    step();
    idleAt(32'h0);
    checkOutput("repair_load_ghr", {26'b0, pred_ghr_g}, 32'h2d);
    checkOutput("repair_load_ghr_bi", {26'b0, pred_ghr_b}, 32'h2d);
    applyStimulus(32'h0, 1'b1, 32'h100, 1'b1, 1'b0, 6'b000011, 1'b1);
    step();
    idleAt(32'h0);
    checkOutput("repair_priority_ghr", {26'b0, pred_ghr_g}, 32'h06);
    checkOutput("repair_priority_ghr_bi", {26'b0, pred_ghr_b}, 32'h06);

    // Aliasing: pc 0x4/ghr 0 and pc 0x0/ghr 1 share entry 1.
    applyStimulus(32'h4, 1'b0, 32'h200, 1'b1, 1'b0, 6'h0, 1'b1);
    step();
    idleAt(32'h4);
    checkOutput("alias_ghr_zero", {26'b0, pred_ghr_g}, 32'd0);
    checkOutput("alias_before", {31'b0, bht_taken_g}, 32'd0);
    applyStimulus(32'h4, 1'b0, 32'h0, 1'b1, 1'b1, 6'h01, 1'b0);
    step();
    idleAt(32'h4);
    checkOutput("alias_flipped", {31'b0, bht_taken_g}, 32'd1);
    applyStimulus(32'h4, 1'b1, 32'h0, 1'b0, 1'b0, 6'h0, 1'b0);
    step();
    idleAt(32'h0);
    checkOutput("alias_ghr_one", {26'b0, pred_ghr_g}, 32'd1);
    checkOutput("alias_pc0_ghr1", {31'b0, bht_taken_g}, 32'd1);
    idleAt(32'h4);
    checkOutput("alias_pc4_ghr1", {31'b0, bht_taken_g}, 32'd0);

    // Same-cycle read/write on entry 9 (pc 0x20 ^ ghr 1), counter starts at 1.
    applyStimulus(32'h20, 1'b0, 32'h20, 1'b1, 1'b1, 6'h01, 1'b0);
    checkOutput("rw_same_cycle_old", {31'b0, bht_taken_g}, 32'd0);
    step();
    idleAt(32'h20);
    checkOutput("rw_next_cycle_new", {31'b0, bht_taken_g}, 32'd1);

    // Back-to-back training: 2 -> 1 -> 0, then 0 -> 1 -> 2.
    applyStimulus(32'h20, 1'b0, 32'h20, 1'b1, 1'b0, 6'h01, 1'b0);
    step();
    step();
    applyStimulus(32'h20, 1'b0, 32'h20, 1'b1, 1'b1, 6'h01, 1'b0);
    checkOutput("b2b_down_to_zero", {31'b0, bht_taken_g}, 32'd0);
    step();
    checkOutput("b2b_up_one", {31'b0, bht_taken_g}, 32'd0);
    step();
    idleAt(32'h20);
    checkOutput("b2b_up_two", {31'b0, bht_taken_g}, 32'd1);

    // Asynchronous reset during training.
    applyStimulus(32'h20, 1'b1, 32'h20, 1'b1, 1'b1, 6'h01, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("rst_train_init_done", {31'b0, init_done_g}, 32'd0);
    checkOutput("rst_train_bht", {31'b0, bht_taken_g}, 32'd0);
    checkOutput("rst_train_ghr", {26'b0, pred_ghr_g}, 32'd0);
    step();
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
